// File: rtl/vreg_port_arbiter.sv
// ---------------------------------------------------------------------------
// vreg_port_arbiter
//   Shares one lane vector-register port among NUM_REQ requesters.
//   A round-robin arbiter picks one eligible requester while IDLE, latches its
//   command into output registers, and holds it on the downstream port (ISSUE)
//   until the port accepts it. Granted reads push the winner ID into an
//   in-order FIFO so read responses can be steered back to their requester.
//
// Ports
//   clk, reset          : clock, asynchronous active-low reset
//   req_vld/we/addr/wdata : per-requester command (flattened, requester i at
//                         slice [i*W +: W])
//   req_gnt             : one-hot acceptance pulse (combinational)
//   rsp_vld, rsp_data   : one-hot read-response valid, broadcast read data
//   reg_req_*           : downstream command (registered)
//   reg_req_grant       : downstream acceptance
//   reg_rsp_vld/data    : downstream in-order read response
//   outst_cnt           : number of reads accepted but not yet answered
//   err_underflow       : sticky flag, response arrived with no read pending
// ---------------------------------------------------------------------------
module vreg_port_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int VECTOR_REG_WIDTH = 64,
  parameter int ADDR_W           = 5,
  parameter int MAX_OUTST        = 4,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1,
  localparam int CNT_W = $clog2(MAX_OUTST) + 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_vld,
  input  logic [NUM_REQ-1:0]                  req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]           req_addr,
  input  logic [NUM_REQ*VECTOR_REG_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]                  req_gnt,
  output logic [NUM_REQ-1:0]                  rsp_vld,
  output logic [VECTOR_REG_WIDTH-1:0]         rsp_data,
  output logic                                reg_req_vld,
  output logic                                reg_req_we,
  output logic [ADDR_W-1:0]                   reg_req_addr,
  output logic [VECTOR_REG_WIDTH-1:0]         reg_req_wdata,
  input  logic                                reg_req_grant,
  input  logic                                reg_rsp_vld,
  input  logic [VECTOR_REG_WIDTH-1:0]         reg_rsp_data,
  output logic [CNT_W-1:0]                    outst_cnt,
  output logic                                err_underflow
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win_id;

  // In-order ID FIFO for reads that have been accepted downstream
  logic [IDX_W-1:0] id_fifo [MAX_OUTST];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic [NUM_REQ-1:0] elig;
  logic               can_read;
  logic               any_elig;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W:0]     rot_sum;
  logic [IDX_W-1:0]   rot_idx;
  logic               fire;
  logic               push;
  logic               pop;
  logic               fifo_empty;

  // Reads are held off once the response FIFO is full; writes never are.
  assign can_read   = (outst_cnt < CNT_W'(MAX_OUTST));
  assign elig       = req_vld & (req_we | {NUM_REQ{can_read}});
  assign fifo_empty = (outst_cnt == '0);

  assign fire = (state == ISSUE) && reg_req_grant;
  assign push = fire && !reg_req_we;
  assign pop  = reg_rsp_vld && !fifo_empty;

  // Rotating priority search: offset 0 from rr_ptr has highest priority.
  always_comb begin
    any_elig = 1'b0;
    pick     = '0;
    rot_sum  = '0;
    rot_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rot_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (rot_sum >= (IDX_W+1)'(NUM_REQ)) begin
        rot_sum = rot_sum - (IDX_W+1)'(NUM_REQ);
      end
      rot_idx = rot_sum[IDX_W-1:0];
      if (!any_elig && elig[rot_idx]) begin
        any_elig = 1'b1;
        pick     = rot_idx;
      end
    end
  end

  always_comb begin
    req_gnt = '0;
    if (fire) begin
      req_gnt[win_id] = 1'b1;
    end
  end

  always_comb begin
    rsp_vld = '0;
    if (pop) begin
      rsp_vld[id_fifo[rd_ptr]] = 1'b1;
    end
  end

  assign rsp_data = reg_rsp_data;

  // Arbitration FSM and downstream command registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      win_id        <= '0;
      reg_req_vld   <= 1'b0;
      reg_req_we    <= 1'b0;
      reg_req_addr  <= '0;
      reg_req_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_elig) begin
            state         <= ISSUE;
            win_id        <= pick;
            reg_req_vld   <= 1'b1;
            reg_req_we    <= req_we[pick];
            reg_req_addr  <= req_addr[pick*ADDR_W +: ADDR_W];
            reg_req_wdata <= req_wdata[pick*VECTOR_REG_WIDTH +: VECTOR_REG_WIDTH];
          end
        end
        ISSUE: begin
          if (reg_req_grant) begin
            state       <= IDLE;
            reg_req_vld <= 1'b0;
            rr_ptr      <= (win_id == IDX_W'(NUM_REQ-1)) ? '0 : win_id + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response-ID FIFO control
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      outst_cnt     <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTST-1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTST-1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   outst_cnt <= outst_cnt + CNT_W'(1);
        2'b01:   outst_cnt <= outst_cnt - CNT_W'(1);
        default: outst_cnt <= outst_cnt;
      endcase
      if (reg_rsp_vld && fifo_empty) begin
        err_underflow <= 1'b1;
      end
    end
  end

  // FIFO storage carries no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (push) begin
      id_fifo[wr_ptr] <= win_id;
    end
  end

endmodule

// File: tb/tb_vreg_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vreg_port_arbiter
//   Directed scenarios followed by a randomized run, all compared every cycle
//   against a transaction-level reference model (pending-command slot, rotating
//   pointer, queue of outstanding read IDs, sticky underflow bit).
// ---------------------------------------------------------------------------
module tb_vreg_port_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int AW = 5;
  localparam int MO = 4;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_vld;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*W-1:0]  req_wdata;
  logic [N-1:0]    req_gnt;
  logic [N-1:0]    rsp_vld;
  logic [W-1:0]    rsp_data;
  logic            reg_req_vld;
  logic            reg_req_we;
  logic [AW-1:0]   reg_req_addr;
  logic [W-1:0]    reg_req_wdata;
  logic            reg_req_grant = 1'b0;
  logic            reg_rsp_vld = 1'b0;
  logic [W-1:0]    reg_rsp_data = '0;
  logic [CW-1:0]   outst_cnt;
  logic            err_underflow;

  always #5 clk = ~clk;

  vreg_port_arbiter #(
    .NUM_REQ(N), .VECTOR_REG_WIDTH(W), .ADDR_W(AW), .MAX_OUTST(MO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_vld(req_vld), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_gnt(req_gnt), .rsp_vld(rsp_vld), .rsp_data(rsp_data),
    .reg_req_vld(reg_req_vld), .reg_req_we(reg_req_we),
    .reg_req_addr(reg_req_addr), .reg_req_wdata(reg_req_wdata),
    .reg_req_grant(reg_req_grant), .reg_rsp_vld(reg_rsp_vld),
    .reg_rsp_data(reg_rsp_data), .outst_cnt(outst_cnt),
    .err_underflow(err_underflow)
  );

  // Requester-side command state (held until granted)
  bit            p_vld [N];
  bit            p_we  [N];
  logic [AW-1:0] p_addr[N];
  logic [W-1:0]  p_wdata[N];
  bit            auto_drop = 1'b1;

  // Reference model
  bit            m_busy;
  int            m_win;
  int            m_rr;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_wdata;
  int            q[$];
  bit            m_err;

  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc;
  logic [N-1:0]  last_gnt;
  logic [N-1:0]  one = 1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_vld[i]              = p_vld[i];
      req_we[i]               = p_we[i];
      req_addr[i*AW +: AW]    = p_addr[i];
      req_wdata[i*W +: W]     = p_wdata[i];
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_win = 0; m_rr = 0; m_err = 0;
    m_we = 0; m_addr = '0; m_wdata = '0;
    q.delete();
  endtask

  // One clock cycle: called at a negedge with inputs set; checks, then
  // advances the model across the rising edge.
  task automatic cycle();
    logic [N-1:0] eg, er;
    int qs, push_id;
    bit found;
    drive();
    #1;
    qs = q.size();
    eg = (m_busy && reg_req_grant) ? (one << m_win) : '0;
    er = (reg_rsp_vld && qs > 0) ? (one << q[0]) : '0;
    chk("req_gnt", req_gnt, eg);
    chk("rsp_vld", rsp_vld, er);
    chk("reg_req_vld", reg_req_vld, m_busy);
    if (m_busy) begin
      chk("reg_req_we", reg_req_we, m_we);
      chk("reg_req_addr", reg_req_addr, m_addr);
      chk("reg_req_wdata", reg_req_wdata, m_wdata);
    end
    chk("outst_cnt", outst_cnt, qs);
    chk("err_underflow", err_underflow, m_err);
    if (reg_rsp_vld) chk("rsp_data", rsp_data, reg_rsp_data);
    last_gnt = req_gnt;

    push_id = -1;
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (!found && p_vld[i] && (p_we[i] || qs < MO)) begin
          found = 1; m_busy = 1; m_win = i;
          m_we = p_we[i]; m_addr = p_addr[i]; m_wdata = p_wdata[i];
        end
      end
    end else if (reg_req_grant) begin
      if (!m_we) push_id = m_win;
      m_rr = (m_win + 1) % N;
      m_busy = 0;
    end
    if (reg_rsp_vld) begin
      if (qs > 0) void'(q.pop_front());
      else m_err = 1;
    end
    if (push_id >= 0) q.push_back(push_id);

    cyc++;
    @(posedge clk);
    @(negedge clk);
    if (auto_drop)
      for (int i = 0; i < N; i++) if (eg[i]) p_vld[i] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < N; i++) p_vld[i] = 0;
    reg_req_grant = 1'b1;
    reg_rsp_vld = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_gnt", req_gnt, '0);
    chk("rst_rsp_vld", rsp_vld, '0);
    chk("rst_reg_req_vld", reg_req_vld, '0);
    chk("rst_reg_req_we", reg_req_we, '0);
    chk("rst_reg_req_addr", reg_req_addr, '0);
    chk("rst_reg_req_wdata", reg_req_wdata, '0);
    chk("rst_outst_cnt", outst_cnt, '0);
    chk("rst_err", err_underflow, '0);
    reg_req_grant = 1'b0;
    model_reset();
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic run_until_gnt(input int i, input int budget);
    last_gnt = '0;
    for (int c = 0; c < budget; c++) begin
      cycle();
      if (last_gnt != '0) break;
    end
    chk($sformatf("gnt_to_%0d", i), last_gnt, one << i);
  endtask

  task automatic issue(input int i, input bit we, input logic [AW-1:0] a, input logic [W-1:0] d);
    p_vld[i] = 1; p_we[i] = we; p_addr[i] = a; p_wdata[i] = d;
    reg_req_grant = 1'b1;
    run_until_gnt(i, 8);
    reg_req_grant = 1'b0;
  endtask

  task automatic respond(input logic [W-1:0] d);
    reg_rsp_vld = 1'b1; reg_rsp_data = d;
    cycle();
    reg_rsp_vld = 1'b0;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$], when[$];
    logic [W-1:0] d0, d1, d2;
    for (int i = 0; i < N; i++) begin
      p_vld[i] = 0; p_we[i] = 0; p_addr[i] = '0; p_wdata[i] = '0;
    end
    drive();
    @(negedge clk);

    // Round-robin over four continuous writers, grant always high
    do_reset();
    auto_drop = 0;
    for (int i = 0; i < N; i++) begin
      p_vld[i] = 1; p_we[i] = 1; p_addr[i] = AW'(i + 8); p_wdata[i] = {$urandom, $urandom};
    end
    reg_req_grant = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (last_gnt != '0) begin
        order.push_back(oh2i(last_gnt));
        when.push_back(cyc);
      end
    end
    chk("rr_gnt_count", order.size(), 5);
    for (int k = 0; k < order.size(); k++) begin
      chk($sformatf("rr_order_%0d", k), order[k], k % N);
      chk($sformatf("rr_cycle_%0d", k), when[k], 2 * (k + 1));
    end
    auto_drop = 1;
    for (int i = 0; i < N; i++) p_vld[i] = 0;
    reg_req_grant = 1'b0;

    // Downstream stall: command must stay stable until accepted
    do_reset();
    p_vld[2] = 1; p_we[2] = 0; p_addr[2] = 5'h13; p_wdata[2] = 64'hDEAD_BEEF_0123_4567;
    cycle();
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("stall_addr", reg_req_addr, 5'h13);
      chk("stall_wdata", reg_req_wdata, 64'hDEAD_BEEF_0123_4567);
      chk("stall_gnt", last_gnt, '0);
    end
    reg_req_grant = 1'b1;
    cycle();
    chk("stall_gnt_final", last_gnt, 4'b0100);
    reg_req_grant = 1'b0;
    cycle();
    chk("stall_outst", outst_cnt, 1);
    respond(64'h1111);

    // Responses routed in issue order
    do_reset();
    issue(1, 0, 5'd1, '0);
    issue(3, 0, 5'd3, '0);
    issue(0, 0, 5'd0, '0);
    d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom}; d2 = {$urandom, $urandom};
    reg_rsp_vld = 1'b1; reg_rsp_data = d0; drive(); #1;
    chk("order_rsp0", rsp_vld, 4'b0010); chk("order_data0", rsp_data, d0);
    @(negedge clk); reg_rsp_vld = 1'b0;
    q.delete(); q.push_back(3); q.push_back(0);
    reg_rsp_vld = 1'b1; reg_rsp_data = d1; drive(); #1;
    chk("order_rsp1", rsp_vld, 4'b1000); chk("order_data1", rsp_data, d1);
    @(negedge clk);
    void'(q.pop_front());
    reg_rsp_data = d2; drive(); #1;
    chk("order_rsp2", rsp_vld, 4'b0001); chk("order_data2", rsp_data, d2);
    @(negedge clk);
    void'(q.pop_front());
    reg_rsp_vld = 1'b0;
    cycle();
    chk("order_outst_end", outst_cnt, 0);

    // Full FIFO: reads blocked, writes still granted
    do_reset();
    for (int i = 0; i < N; i++) issue(i, 0, AW'(i), '0);
    chk("full_outst", outst_cnt, 4);
    p_vld[0] = 1; p_we[0] = 0; p_addr[0] = 5'h1A;
    p_vld[1] = 1; p_we[1] = 1; p_addr[1] = 5'h1B; p_wdata[1] = {$urandom, $urandom};
    reg_req_grant = 1'b1;
    run_until_gnt(1, 8);
    cycle(); cycle();
    chk("full_blocked", reg_req_vld, 1'b0);
    respond({$urandom, $urandom});
    run_until_gnt(0, 8);
    reg_req_grant = 1'b0;
    while (q.size() > 0) respond({$urandom, $urandom});

    // Simultaneous push and pop, then underflow
    do_reset();
    issue(0, 0, 5'd2, '0);
    issue(1, 0, 5'd4, '0);
    p_vld[2] = 1; p_we[2] = 0; p_addr[2] = 5'd6;
    cycle();
    reg_req_grant = 1'b1; reg_rsp_vld = 1'b1; reg_rsp_data = {$urandom, $urandom};
    cycle();
    chk("pp_gnt", last_gnt, 4'b0100);
    reg_req_grant = 1'b0; reg_rsp_vld = 1'b0;
    cycle();
    chk("pp_outst", outst_cnt, 2);
    respond({$urandom, $urandom});
    respond({$urandom, $urandom});
    chk("pp_outst_empty", outst_cnt, 0);
    respond({$urandom, $urandom});
    chk("uf_no_rsp", last_gnt, '0);
    cycle();
    chk("uf_sticky", err_underflow, 1'b1);
    cycle();
    chk("uf_sticky2", err_underflow, 1'b1);

    // Reset in the middle of ISSUE
    do_reset();
    p_vld[2] = 1; p_we[2] = 1; p_addr[2] = 5'd9; p_wdata[2] = {$urandom, $urandom};
    cycle();
    cycle();
    chk("mid_issue_vld", reg_req_vld, 1'b1);
    reg_req_grant = 1'b1; drive();
    #3 reset = 1'b0;
    #1;
    chk("async_rst_vld", reg_req_vld, 1'b0);
    chk("async_rst_gnt", req_gnt, '0);
    do_reset();
    p_vld[0] = 1; p_we[0] = 1; p_addr[0] = 5'd1;
    p_vld[2] = 1; p_we[2] = 1; p_addr[2] = 5'd9;
    reg_req_grant = 1'b1;
    run_until_gnt(0, 8);
    reg_req_grant = 1'b0;

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!p_vld[i] && $urandom_range(0, 2) == 0) begin
          p_vld[i] = 1; p_we[i] = $urandom_range(0, 1);
          p_addr[i] = AW'($urandom); p_wdata[i] = {$urandom, $urandom};
        end
      end
      reg_req_grant = $urandom_range(0, 1);
      reg_rsp_vld = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      reg_rsp_data = {$urandom, $urandom};
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
